// File: rtl/bloom_filter_driver.sv
// Request-side initiator for the Bloom filter core: queues insert/query requests,
// strobes the core one request at a time and returns tagged responses with a watchdog.
module bloom_filter_driver #(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_op,
  input  logic [31:0]            req_data,
  input  logic [TAG_W-1:0]       req_tag,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic                   resp_op,
  output logic [TAG_W-1:0]       resp_tag,
  output logic                   resp_match,
  output logic                   resp_err,
  output logic                   bf_insert,
  output logic                   bf_query,
  output logic [31:0]            bf_data,
  input  logic                   bf_busy,
  input  logic                   bf_match,
  output logic [$clog2(DEPTH):0] fifo_count
);
  localparam int                 PTR_W = $clog2(DEPTH);
  localparam int                 CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [PTR_W:0]     FULL  = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]     ONE   = (PTR_W + 1)'(1);
  localparam logic [CNT_W-1:0]   TMO   = CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP} state_e;

  typedef struct packed {
    logic             op;
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  state_e           state_q, state_d;
  cmd_t             mem_q [DEPTH];
  cmd_t             cmd_q, cmd_d, head;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic             cap_q, cap_d;
  logic             ins_q, ins_d, qry_q, qry_d;
  logic             resp_op_q, resp_op_d;
  logic [TAG_W-1:0] resp_tag_q, resp_tag_d;
  logic             resp_match_q, resp_match_d;
  logic             resp_err_q, resp_err_d;
  logic             push, pop, load_resp, wd_err;

  assign head       = mem_q[rd_ptr_q];
  assign req_ready  = (count_q != FULL);
  assign push       = req_valid && req_ready;
  assign fifo_count = count_q;
  assign resp_valid = (state_q == RESP);
  assign resp_op    = resp_op_q;
  assign resp_tag   = resp_tag_q;
  assign resp_match = resp_match_q;
  assign resp_err   = resp_err_q;
  assign bf_insert  = ins_q;
  assign bf_query   = qry_q;
  assign bf_data    = cmd_q.data;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d   = state_q;
    pop       = 1'b0;
    load_resp = 1'b0;
    wd_err    = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0 && !bf_busy) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT_BUSY;
      WAIT_BUSY: begin
        if (bf_busy) begin
          state_d = WAIT_DONE;
        end else if (wcnt_q == TMO) begin
          load_resp = 1'b1;
          wd_err    = 1'b1;
          state_d   = RESP;
        end
      end
      WAIT_DONE: begin
        if (!bf_busy) begin
          load_resp = 1'b1;
          state_d   = RESP;
        end else if (wcnt_q == TMO) begin
          load_resp = 1'b1;
          wd_err    = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + ONE;
    else if (!push && pop) count_d = count_q - ONE;

    cmd_d = pop ? head : cmd_q;
    ins_d = pop && !head.op;
    qry_d = pop && head.op;

    // Any state change restarts the watchdog, which covers entry to both wait states.
    if (state_d != state_q)  wcnt_d = '0;
    else if (wcnt_q == TMO)  wcnt_d = wcnt_q;
    else                     wcnt_d = wcnt_q + CNT_W'(1);

    cap_d = cap_q;
    if (pop) cap_d = 1'b0;
    else if ((state_q == WAIT_BUSY || state_q == WAIT_DONE) && bf_busy) cap_d = bf_match;

    resp_op_d    = resp_op_q;
    resp_tag_d   = resp_tag_q;
    resp_match_d = resp_match_q;
    resp_err_d   = resp_err_q;
    if (load_resp) begin
      resp_op_d    = cmd_q.op;
      resp_tag_d   = cmd_q.tag;
      resp_err_d   = wd_err;
      resp_match_d = cap_q & cmd_q.op & ~wd_err;
    end
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      cmd_q        <= '0;
      wcnt_q       <= '0;
      cap_q        <= 1'b0;
      ins_q        <= 1'b0;
      qry_q        <= 1'b0;
      resp_op_q    <= 1'b0;
      resp_tag_q   <= '0;
      resp_match_q <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      cmd_q        <= cmd_d;
      wcnt_q       <= wcnt_d;
      cap_q        <= cap_d;
      ins_q        <= ins_d;
      qry_q        <= qry_d;
      resp_op_q    <= resp_op_d;
      resp_tag_q   <= resp_tag_d;
      resp_match_q <= resp_match_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // NOTE: FIFO storage has no reset; the cleared count and pointers already mark it empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= cmd_t'{op: req_op, data: req_data, tag: req_tag};
  end

endmodule

// File: tb/tb_bloom_filter_driver.sv
// Directed bench for bloom_filter_driver with a behavioural core model that can also
// act as a never-busy or stuck-busy stub.
module tb_bloom_filter_driver;
  localparam int DEPTH   = 4;
  localparam int TAG_W   = 4;
  localparam int TIMEOUT = 16;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   req_valid, req_ready, req_op;
  logic [31:0]            req_data;
  logic [TAG_W-1:0]       req_tag;
  logic                   resp_valid, resp_ready, resp_op, resp_match, resp_err;
  logic [TAG_W-1:0]       resp_tag;
  logic                   bf_insert, bf_query, bf_busy, bf_match;
  logic [31:0]            bf_data;
  logic [$clog2(DEPTH):0] fifo_count;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  bloom_filter_driver #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_data(req_data), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_op(resp_op),
    .resp_tag(resp_tag), .resp_match(resp_match), .resp_err(resp_err),
    .bf_insert(bf_insert), .bf_query(bf_query), .bf_data(bf_data),
    .bf_busy(bf_busy), .bf_match(bf_match), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Core model. mode 0: nominal (insert busy 2 cycles, query busy 3 with match on the
  // last); mode 1: busy tied low; mode 2: busy stuck high after a strobe, match high.
  int          mode     = 0;
  logic        ext_busy = 1'b0;
  logic [1:0]  ph_q;
  logic        qop_q, hit_q, stuck_q;
  logic [31:0] set_q [8];
  int          set_n;

  function automatic logic in_set(input logic [31:0] d);
    for (int i = 0; i < 8; i++) if (i < set_n && set_q[i] == d) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ph_q <= 2'd0; qop_q <= 1'b0; hit_q <= 1'b0; stuck_q <= 1'b0; set_n <= 0;
    end else begin
      if (mode != 2) stuck_q <= 1'b0;
      if (bf_insert || bf_query) begin
        if (mode == 2) stuck_q <= 1'b1;
        ph_q  <= 2'd1;
        qop_q <= bf_query;
        hit_q <= in_set(bf_data);
        if (bf_insert && set_n < 8) begin
          set_q[set_n] <= bf_data;
          set_n        <= set_n + 1;
        end
      end else if (ph_q == 2'd1) ph_q <= 2'd2;
      else if (ph_q == 2'd2)     ph_q <= qop_q ? 2'd3 : 2'd0;
      else                       ph_q <= 2'd0;
    end
  end

  assign bf_busy  = (mode == 1) ? 1'b0 : (ext_busy || ph_q != 2'd0 || (stuck_q && mode == 2));
  assign bf_match = (mode == 2) ? 1'b1 : (ph_q == 2'd3 && hit_q);

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic push(input logic op, input logic [31:0] data, input logic [TAG_W-1:0] tag,
                      output int acc);
    int n = 0;
    req_valid = 1'b1; req_op = op; req_data = data; req_tag = tag;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    if (!req_ready) begin
      tests_run++; tests_failed++;
      $display("FAIL push_timeout tag=%0d: req_ready=0, required 1", tag);
    end
    acc = cyc;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_strobe(output int t);
    int n = 0;
    while (!(bf_insert || bf_query) && n < 100) begin @(negedge clk); n++; end
    tests_run++;
    if (!(bf_insert || bf_query) || (bf_insert && bf_query)) begin
      tests_failed++;
      $display("FAIL strobe: insert=%b query=%b, required exactly one high", bf_insert, bf_query);
    end
    t = cyc;
  endtask

  task automatic wait_resp(input bit accept, output logic op, output logic [TAG_W-1:0] tag,
                           output logic m, output logic e, output int t);
    int n = 0;
    while (!resp_valid && n < 100) begin @(negedge clk); n++; end
    if (!resp_valid) begin
      tests_run++; tests_failed++;
      $display("FAIL resp_timeout: resp_valid=0, required 1");
    end
    t = cyc; op = resp_op; tag = resp_tag; m = resp_match; e = resp_err;
    if (accept) begin
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests_run++; if (fifo_count !== 3'd0) begin tests_failed++; $display("FAIL reset_fifo_count: got %0d, required 0", fifo_count); end
    tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_req_ready: got %b, required 1", req_ready); end
    tests_run++; if ({resp_valid, resp_match, resp_err, resp_op} !== 4'b0) begin tests_failed++; $display("FAIL reset_resp: got v/m/e/op=%b, required 0000", {resp_valid, resp_match, resp_err, resp_op}); end
    tests_run++; if (resp_tag !== 4'd0) begin tests_failed++; $display("FAIL reset_resp_tag: got %0d, required 0", resp_tag); end
    tests_run++; if ({bf_insert, bf_query} !== 2'b00 || bf_data !== 32'd0) begin tests_failed++; $display("FAIL reset_core_if: got ins/qry=%b data=%h, required 00 / 0", {bf_insert, bf_query}, bf_data); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    tests_run++; if ({bf_insert, bf_query, resp_valid} !== 3'b000) begin tests_failed++; $display("FAIL idle_empty: got ins/qry/rv=%b, required 000", {bf_insert, bf_query, resp_valid}); end
  endtask

  task automatic test_insert_query();
    int acc, t, tr;
    logic op, m, e;
    logic [TAG_W-1:0] tag;
    push(1'b0, 32'h0000_1234, 4'd3, acc);
    wait_strobe(t);
    tests_run++; if (t - acc !== 2) begin tests_failed++; $display("FAIL issue_latency: got %0d, required 2", t - acc); end
    tests_run++; if (bf_insert !== 1'b1 || bf_data !== 32'h0000_1234) begin tests_failed++; $display("FAIL insert_strobe: got ins=%b data=%h, required 1 / 00001234", bf_insert, bf_data); end
    wait_resp(1'b1, op, tag, m, e, tr);
    tests_run++; if (tr - t !== 4) begin tests_failed++; $display("FAIL insert_latency: got %0d, required 4", tr - t); end
    tests_run++; if ({op, tag, m, e} !== {1'b0, 4'd3, 1'b0, 1'b0}) begin tests_failed++; $display("FAIL insert_resp: got op=%b tag=%0d m=%b e=%b, required 0 3 0 0", op, tag, m, e); end
    push(1'b1, 32'h0000_1234, 4'd4, acc);
    wait_strobe(t);
    tests_run++; if (bf_query !== 1'b1 || bf_insert !== 1'b0) begin tests_failed++; $display("FAIL query_strobe: got ins=%b qry=%b, required 0 1", bf_insert, bf_query); end
    wait_resp(1'b1, op, tag, m, e, tr);
    tests_run++; if (tr - t !== 5) begin tests_failed++; $display("FAIL query_latency: got %0d, required 5", tr - t); end
    tests_run++; if ({op, tag, m, e} !== {1'b1, 4'd4, 1'b1, 1'b0}) begin tests_failed++; $display("FAIL query_resp: got op=%b tag=%0d m=%b e=%b, required 1 4 1 0", op, tag, m, e); end
  endtask

  task automatic test_fresh_query();
    int acc, tr;
    logic op, m, e;
    logic [TAG_W-1:0] tag;
    do_reset();
    push(1'b1, 32'hDEAD_BEEF, 4'd5, acc);
    wait_resp(1'b1, op, tag, m, e, tr);
    tests_run++; if ({op, tag, m, e} !== {1'b1, 4'd5, 1'b0, 1'b0}) begin tests_failed++; $display("FAIL fresh_query: got op=%b tag=%0d m=%b e=%b, required 1 5 0 0", op, tag, m, e); end
  endtask

  task automatic test_back_to_back();
    int acc, tr, n;
    logic op, m, e;
    logic [TAG_W-1:0] tag;
    ext_busy = 1'b1;
    for (int i = 0; i < DEPTH; i++) push(1'(i), 32'h100 + 32'(i), 4'(i), acc);
    tests_run++; if (fifo_count !== 3'(DEPTH) || req_ready !== 1'b0) begin tests_failed++; $display("FAIL full: got count=%0d ready=%b, required %0d 0", fifo_count, req_ready, DEPTH); end
    tests_run++; if ({bf_insert, bf_query} !== 2'b00) begin tests_failed++; $display("FAIL busy_defer: got ins/qry=%b, required 00", {bf_insert, bf_query}); end
    req_valid = 1'b1; req_op = 1'b0; req_data = 32'h100 + 32'(DEPTH); req_tag = 4'(DEPTH);
    repeat (3) @(negedge clk);
    tests_run++; if (fifo_count !== 3'(DEPTH) || req_ready !== 1'b0) begin tests_failed++; $display("FAIL full_ignore: got count=%0d ready=%b, required %0d 0", fifo_count, req_ready, DEPTH); end
    ext_busy = 1'b0;
    n = 0;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid = 1'b0;
    wait_resp(1'b0, op, tag, m, e, tr);
    repeat (4) @(negedge clk);
    tests_run++; if ({resp_valid, resp_op, resp_tag, resp_match, resp_err} !== {1'b1, 1'b0, 4'd0, 1'b0, 1'b0}) begin tests_failed++; $display("FAIL resp_hold: got v=%b op=%b tag=%0d m=%b e=%b, required 1 0 0 0 0", resp_valid, resp_op, resp_tag, resp_match, resp_err); end
    resp_ready = 1'b0;
    for (int i = 0; i <= DEPTH; i++) begin
      wait_resp(1'b1, op, tag, m, e, tr);
      tests_run++; if ({op, tag, m, e} !== {1'(i), 4'(i), 1'b0, 1'b0}) begin tests_failed++; $display("FAIL order_%0d: got op=%b tag=%0d m=%b e=%b, required %b %0d 0 0", i, op, tag, m, e, 1'(i), i); end
    end
  endtask

  task automatic test_watchdog_idle();
    int acc, t, tr;
    logic op, m, e;
    logic [TAG_W-1:0] tag;
    mode = 1;
    push(1'b1, 32'h0000_CAFE, 4'd6, acc);
    wait_strobe(t);
    wait_resp(1'b1, op, tag, m, e, tr);
    tests_run++; if (tr - t !== TIMEOUT + 2) begin tests_failed++; $display("FAIL wd_busy_latency: got %0d, required %0d", tr - t, TIMEOUT + 2); end
    tests_run++; if ({tag, m, e} !== {4'd6, 1'b0, 1'b1}) begin tests_failed++; $display("FAIL wd_busy_resp: got tag=%0d m=%b e=%b, required 6 0 1", tag, m, e); end
    mode = 0;
  endtask

  task automatic test_watchdog_stuck();
    int acc, t, tr;
    logic op, m, e;
    logic [TAG_W-1:0] tag;
    mode = 2;
    push(1'b1, 32'h0000_BEEF, 4'd7, acc);
    wait_strobe(t);
    wait_resp(1'b1, op, tag, m, e, tr);
    tests_run++; if (tr - t < TIMEOUT + 2 || tr - t > TIMEOUT + 4) begin tests_failed++; $display("FAIL wd_done_latency: got %0d, required %0d..%0d", tr - t, TIMEOUT + 2, TIMEOUT + 4); end
    tests_run++; if ({tag, m, e} !== {4'd7, 1'b0, 1'b1}) begin tests_failed++; $display("FAIL wd_done_resp: got tag=%0d m=%b e=%b, required 7 0 1", tag, m, e); end
    mode = 0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int acc, t, tr, seen;
    logic op, m, e;
    logic [TAG_W-1:0] tag;
    mode = 2;
    for (int i = 0; i < 3; i++) push(1'b1, 32'(i + 1), 4'(8 + i), acc);
    repeat (4) @(negedge clk);
    tests_run++; if (fifo_count !== 3'd2 || bf_busy !== 1'b1) begin tests_failed++; $display("FAIL pre_reset: got count=%0d busy=%b, required 2 1", fifo_count, bf_busy); end
    rst = 1'b1;
    #1;
    tests_run++; if ({bf_query, bf_insert} !== 2'b00 || fifo_count !== 3'd0) begin tests_failed++; $display("FAIL mid_reset: got qry/ins=%b count=%0d, required 00 0", {bf_query, bf_insert}, fifo_count); end
    @(negedge clk);
    rst  = 1'b0;
    mode = 0;
    seen = 0;
    repeat (30) begin @(negedge clk); if (resp_valid) seen++; end
    tests_run++; if (seen !== 0) begin tests_failed++; $display("FAIL no_resp_after_reset: got %0d valid cycles, required 0", seen); end
    push(1'b1, 32'h0000_1234, 4'd11, acc);
    wait_strobe(t);
    wait_resp(1'b1, op, tag, m, e, tr);
    tests_run++; if (tr - t !== 5 || {op, tag, m, e} !== {1'b1, 4'd11, 1'b0, 1'b0}) begin tests_failed++; $display("FAIL post_reset: got lat=%0d op=%b tag=%0d m=%b e=%b, required 5 1 11 0 0", tr - t, op, tag, m, e); end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = 1'b0; req_data = '0; req_tag = '0; resp_ready = 1'b0;
    test_reset();
    test_insert_query();
    test_fresh_query();
    test_back_to_back();
    test_watchdog_idle();
    test_watchdog_stuck();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/bloom_filter_driver.md
# bloom_filter_driver

Request-side initiator for the Bloom filter core. Accepts insert/query requests on a valid/ready stream, buffers them in a small FIFO, and drives the core's single-cycle `insert`/`query` strobes while tracking its `busy` handshake. Captures the core's `match` result and returns one tagged response per request on a valid/ready stream. A watchdog reports a stalled core as an error instead of hanging.

## Interface
Parameters:
- `DEPTH`, 4: request FIFO entries; power of two, at least 2.
- `TAG_W`, 4: width of the request/response tag.
- `TIMEOUT`, 16: maximum cycles allowed in each wait state before an error response.

Ports:
- `clk`  in  1: single clock; all logic is rising-edge.
- `rst`  in  1: asynchronous, active-high reset.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: high when the FIFO is not full.
- `req_op`  in  1: operation select; 0 = insert, 1 = query.
- `req_data`  in  32: element to insert or query.
- `req_tag`  in  TAG_W: tag returned unchanged with the response.
- `resp_valid`  out  1: response present.
- `resp_ready`  in  1: consumer accepts the response.
- `resp_op`  out  1: op of the completed request.
- `resp_tag`  out  TAG_W: tag of the completed request.
- `resp_match`  out  1: query result; always 0 for insert or on error.
- `resp_err`  out  1: watchdog expired.
- `bf_insert`  out  1: insert strobe to the core.
- `bf_query`  out  1: query strobe to the core.
- `bf_data`  out  32: element to the core.
- `bf_busy`  in  1: core busy.
- `bf_match`  in  1: core match output.
- `fifo_count`  out  $clog2(DEPTH)+1: current FIFO occupancy.

## Operation
- FIFO push: occurs when `req_valid && req_ready`. Push and pop in the same cycle are legal and leave the count unchanged.
- FIFO ordering: responses are returned in strict FIFO order, with exactly one response per accepted request.
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP.
- IDLE: when the FIFO is non-empty and `bf_busy`=0:
  - pop the head into the command register (op, data, tag);
  - go to ISSUE.
- ISSUE: held for exactly one cycle.
  - `bf_insert` = (op==0) and `bf_query` = (op==1), both registered.
  - Always go to WAIT_BUSY.
- WAIT_BUSY:
  - if `bf_busy`=1, go to WAIT_DONE;
  - else if the wait counter reaches TIMEOUT, load an error response and go to RESP.
- WAIT_DONE:
  - each cycle `bf_busy`=1, register `bf_match` into the match-capture flop;
  - when `bf_busy`=0, load the response and go to RESP;
  - if TIMEOUT cycles pass with `bf_busy` still 1, load an error response and go to RESP.
- Match capture: the capture flop is also written during WAIT_BUSY cycles that see `bf_busy`=1. It therefore holds `bf_match` from the last busy cycle, which is the core's CHECK cycle.
- Response contents:
  - op and tag come from the command register;
  - `resp_match` = captured value & op & !err;
  - `resp_err` = watchdog flag.
- RESP: `resp_valid`=1 with all response fields stable until `resp_ready`=1. Return to IDLE on the following cycle.
- Wait counter: cleared on entry to WAIT_BUSY and WAIT_DONE; saturates at TIMEOUT.
- `bf_data`: equals the command register from ISSUE through the end of WAIT_DONE, which holds it stable across the core's whole hash window.
- Strobes: `bf_insert` and `bf_query` are never high together and never high outside ISSUE.

## Timing
- Reset values:
  - FSM in IDLE, FIFO empty;
  - `fifo_count`=0;
  - `req_ready`=1;
  - `resp_valid`=0, `resp_match`=0, `resp_err`=0, `resp_op`=0, `resp_tag`=0;
  - `bf_insert`=0, `bf_query`=0, `bf_data`=0.
- Reset mid-operation:
  - the strobes drop immediately (asynchronous reset);
  - in-flight and queued requests are discarded, with no response;
  - the core is reset on the same `rst`.
- Issue latency: a request pushed into an empty FIFO at cycle c is popped at c+1 and strobed in ISSUE at c+2.
- Response latency against a nominal core, with strobe at cycle t:
  - insert: busy during t+1..t+2, `resp_valid` rises at t+4;
  - query: busy during t+1..t+3, match valid at t+3, `resp_valid` rises at t+5.
- Watchdog: if the core never asserts busy, `resp_valid` rises TIMEOUT+2 cycles after ISSUE with `resp_err`=1.
- Busy at pop time: if `bf_busy`=1 while in IDLE (core busy from another source), the pop is deferred until `bf_busy`=0.
- Full FIFO: `req_ready`=0; `req_valid` is ignored.
- Empty FIFO: FSM stays in IDLE; no strobes.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Throughput: at most one request in flight at the core.

## Test plan
- Insert 0x0000_1234 with tag 3, then query 0x0000_1234 with tag 4, against the real core:
  - responses in order: (op0, tag3, match0, err0), then (op1, tag4, match1, err0);
  - query `resp_valid` 5 cycles after `bf_query`.
- Query 0xDEAD_BEEF on a freshly reset core -> `resp_match`=0, `resp_err`=0.
- Push DEPTH+1 requests back-to-back with `resp_ready`=0:
  - `req_ready` falls after DEPTH accepts, with `fifo_count`=DEPTH;
  - the first response is held stable until `resp_ready`=1;
  - all tags return in order.
- Stub core with `bf_busy` tied 0 -> response with `resp_err`=1, `resp_match`=0, exactly TIMEOUT+2 cycles after ISSUE.
- Stub core with `bf_busy` stuck at 1 after the strobe -> `resp_err`=1 after the WAIT_DONE timeout.
- Assert `rst` during WAIT_DONE with 2 entries queued:
  - `bf_query`=0 and `fifo_count`=0 immediately;
  - no response is produced;
  - the next request completes normally.
